// File: rtl/norm_sq_seq_if.sv
// Vector-in / squared-magnitude-out handshake bundle.
// master drives the vector and out_ready; slave is the unit.
interface norm_sq_seq_if #(
    parameter int N     = 16,
    parameter int OUT_W = 24
);
    logic signed [N-1:0] in_x;
    logic signed [N-1:0] in_y;
    logic signed [N-1:0] in_z;
    logic                in_valid;
    logic                in_ready;
    logic [OUT_W-1:0]    out_sum;
    logic                out_sat;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_x, in_y, in_z, in_valid, out_ready,
        input  in_ready, out_sum, out_sat, out_valid
    );

    modport slave (
        input  in_x, in_y, in_z, in_valid, out_ready,
        output in_ready, out_sum, out_sat, out_valid
    );
endinterface

// File: rtl/norm_sq_seq.sv
// Sequential |v|^2 unit: one DRUM squarer shared over x, y, z,
// saturating accumulate, valid/ready result.
module square #(
    parameter int N          = 16,
    parameter int K          = 5,
    parameter int POST_SHIFT = 8
) (
    input  logic signed [N-1:0] a,
    output logic [2*N-1:0]      y
);
    localparam int LW = $clog2(N);
    localparam int PW = 2 * N;

    logic [N-1:0]  mag;
    logic [LW-1:0] lead;
    logic [LW-1:0] shamt;
    logic [K-1:0]  trunc;
    logic [PW-1:0] full;

    always_comb begin
        mag   = a[N-1] ? (~$unsigned(a) + 1'b1) : $unsigned(a);
        lead  = '0;
        shamt = '0;
        trunc = '0;
        full  = '0;
        for (int i = 0; i < N; i++) begin
            if (mag[i]) lead = LW'(i);
        end
        if (lead < LW'(K)) begin
            full = PW'(mag) * PW'(mag);
        end else begin
            // keep K bits below the leading one, force LSB to unbias
            shamt = lead - LW'(K - 1);
            trunc = K'(mag >> shamt) | K'(1);
            full  = (PW'(trunc) * PW'(trunc)) << {shamt, 1'b0};
        end
    end

    assign y = full >> POST_SHIFT;
endmodule

module norm_sq_seq #(
    parameter int N          = 16,
    parameter int K          = 5,
    parameter int POST_SHIFT = 8,
    parameter int OUT_W      = 24
) (
    input  logic          clk,
    input  logic          rst,
    norm_sq_seq_if.slave  bus
);
    localparam int ACC_W = 2 * N + 2;
    localparam logic [ACC_W-1:0] SAT_MAX =
        (ACC_W'(1) << OUT_W) - ACC_W'(1);

    typedef enum logic [2:0] {
        IDLE, SQ_X, SQ_Y, SQ_Z, DONE
    } state_t;

    state_t              state, state_d;
    logic signed [N-1:0] x_q, y_q, z_q;
    logic signed [N-1:0] sq_in;
    logic [2*N-1:0]      sq_out;
    logic [ACC_W-1:0]    acc_q, acc_sum;
    logic [OUT_W-1:0]    sum_q;
    logic                sat_q;
    logic                accept, over, busy_sq;

    square #(
        .N(N), .K(K), .POST_SHIFT(POST_SHIFT)
    ) u_sq (
        .a(sq_in),
        .y(sq_out)
    );

    assign accept  = bus.in_valid && bus.in_ready;
    assign acc_sum = acc_q + ACC_W'(sq_out);
    assign over    = acc_sum > SAT_MAX;

    always_comb begin
        state_d = state;
        sq_in   = '0;
        busy_sq = 1'b0;
        case (state)
            IDLE: if (accept) state_d = SQ_X;
            SQ_X: begin
                sq_in   = x_q;
                busy_sq = 1'b1;
                state_d = SQ_Y;
            end
            SQ_Y: begin
                sq_in   = y_q;
                busy_sq = 1'b1;
                state_d = SQ_Z;
            end
            SQ_Z: begin
                sq_in   = z_q;
                busy_sq = 1'b1;
                state_d = DONE;
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            acc_q <= '0;
            sum_q <= '0;
            sat_q <= 1'b0;
        end else begin
            if (accept) begin
                x_q   <= bus.in_x;
                y_q   <= bus.in_y;
                z_q   <= bus.in_z;
                acc_q <= '0;
            end
            if (busy_sq) acc_q <= acc_sum;
            if (state == SQ_Z) begin
                sum_q <= over ? '1 : acc_sum[OUT_W-1:0];
                sat_q <= over;
            end
        end
    end

    // rst gates in_ready so nothing is accepted while held in reset
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = sum_q;
    assign bus.out_sat   = sat_q;
endmodule

// File: tb/tb_norm_sq_seq.sv
// Bench for norm_sq_seq: 24-bit and 22-bit instances in lockstep,
// checked against an arithmetic DRUM model.
module tb_norm_sq_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [15:0] in_x = '0;
    logic signed [15:0] in_y = '0;
    logic signed [15:0] in_z = '0;
    logic in_valid  = 1'b0;
    logic out_ready = 1'b1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int x;
        int y;
        int z;
    } vec_t;

    norm_sq_seq_if #(.N(16), .OUT_W(24)) bus24 ();
    norm_sq_seq_if #(.N(16), .OUT_W(22)) bus22 ();

    assign bus24.in_x      = in_x;
    assign bus24.in_y      = in_y;
    assign bus24.in_z      = in_z;
    assign bus24.in_valid  = in_valid;
    assign bus24.out_ready = out_ready;
    assign bus22.in_x      = in_x;
    assign bus22.in_y      = in_y;
    assign bus22.in_z      = in_z;
    assign bus22.in_valid  = in_valid;
    assign bus22.out_ready = out_ready;

    norm_sq_seq #(.N(16), .K(5), .POST_SHIFT(8), .OUT_W(24)) dut24 (
        .clk(clk), .rst(rst), .bus(bus24)
    );
    norm_sq_seq #(.N(16), .K(5), .POST_SHIFT(8), .OUT_W(22)) dut22 (
        .clk(clk), .rst(rst), .bus(bus22)
    );

    always #5 clk = ~clk;

    function automatic longint drum(input int v);
        longint a, t, s;
        int p;
        a = (v < 0) ? -longint'(v) : longint'(v);
        p = -1;
        for (int i = 0; i < 17; i++)
            if (a[i]) p = i;
        if (p < 5) begin
            s = a * a;
        end else begin
            t = (a >> (p - 4)) | 64'd1;
            s = (t * t) << (2 * (p - 4));
        end
        return s >> 8;
    endfunction

    function automatic longint model_sum(input vec_t v, input int w);
        longint tot, mx;
        tot = drum(v.x) + drum(v.y) + drum(v.z);
        mx  = (longint'(1) << w) - 1;
        return (tot > mx) ? mx : tot;
    endfunction

    function automatic longint model_sat(input vec_t v, input int w);
        longint tot;
        tot = drum(v.x) + drum(v.y) + drum(v.z);
        return (tot > (longint'(1) << w) - 1) ? 1 : 0;
    endfunction

    function automatic int rnd_comp();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 65535)) - 32768;
            1:       return int'($urandom_range(0, 80)) - 40;
            2:       return ($urandom_range(0, 1) != 0) ? 32767 : -32768;
            default: return int'($urandom_range(0, 2000)) - 1000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input vec_t v);
        chk({tag, ".sum24"}, bus24.out_sum, model_sum(v, 24));
        chk({tag, ".sat24"}, bus24.out_sat, model_sat(v, 24));
        chk({tag, ".sum22"}, bus22.out_sum, model_sum(v, 22));
        chk({tag, ".sat22"}, bus22.out_sat, model_sat(v, 22));
    endtask

    task automatic drive(input vec_t v);
        in_x = 16'(v.x);
        in_y = 16'(v.y);
        in_z = 16'(v.z);
    endtask

    // accept one vector, wait for its result; release if out_ready high
    task automatic send(input string tag, input vec_t v,
                        input longint lit24, input longint lit22);
        int lat;
        @(negedge clk);
        chk({tag, ".rdy"}, bus24.in_ready, 1);
        drive(v);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".busy"}, bus22.in_ready, 0);
        lat = 0;
        while (!bus24.out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, lat, 3);
        chk({tag, ".v22"}, bus22.out_valid, 1);
        chk_outs(tag, v);
        chk({tag, ".excl"}, bus24.in_ready, 0);
        if (lit24 >= 0) chk({tag, ".lit24"}, bus24.out_sum, lit24);
        if (lit22 >= 0) chk({tag, ".lit22"}, bus22.out_sum, lit22);
        if (out_ready) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".vclr"}, bus24.out_valid, 0);
            chk({tag, ".rdy2"}, bus24.in_ready, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, w;
        vec_t q[$];
        int last;
        bit pend;
        longint stall_sum;

        repeat (3) @(negedge clk);
        chk("rst.rdy", bus24.in_ready, 0);
        chk("rst.vld", bus24.out_valid, 0);
        chk("rst.sum", bus24.out_sum, 0);
        chk("rst.sat", bus22.out_sat, 0);
        rst = 1'b0;

        out_ready = 1'b1;
        v = '{16, 31, 0};
        send("t16_31", v, 4, 4);
        v = '{256, -256, 256};
        send("t256", v, 867, 867);
        chk("sym", drum(-256), 289);
        v = '{32767, 0, 0};
        send("tmax1", v, 3936256, 3936256);
        v = '{32767, 32767, 0};
        send("tmax2", v, 7872512, 4194303);
        chk("tmax2.sat", bus22.out_sat, 1);
        v = '{-32768, -32768, -32768};
        send("tneg", v, -1, -1);

        for (int i = 0; i < 12; i++) begin
            v = '{rnd_comp(), rnd_comp(), rnd_comp()};
            send($sformatf("rnd%0d", i), v, -1, -1);
        end

        // stall with out_ready low; pulses on in_* must be ignored
        out_ready = 1'b0;
        v = '{1000, -2000, 3000};
        send("bp", v, -1, -1);
        stall_sum = model_sum(v, 24);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp.hold", bus24.out_sum, stall_sum);
            chk("bp.rdy", bus24.in_ready, 0);
            chk("bp.vld", bus22.out_valid, 1);
            if (i % 3 == 0) begin
                w = '{rnd_comp(), rnd_comp(), rnd_comp()};
                drive(w);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk_outs("bp.end", v);
        @(posedge clk);
        @(negedge clk);
        chk("bp.vclr", bus24.out_valid, 0);
        chk("bp.rdy2", bus24.in_ready, 1);
        v = '{-5, 700, 20000};
        send("bp.next", v, -1, -1);

        // asynchronous reset while squaring y
        @(negedge clk);
        v = '{30000, 30000, 30000};
        drive(v);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar.vld", bus24.out_valid, 0);
        chk("ar.sum", bus24.out_sum, 0);
        chk("ar.sat", bus24.out_sat, 0);
        chk("ar.rdy", bus24.in_ready, 0);
        chk("ar.vld22", bus22.out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar.rel", bus24.in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ar.nov", bus24.out_valid, 0);
        end
        v = '{16, 0, 0};
        send("ar.after", v, 1, 1);

        // back-to-back with in_valid held high
        last = -1;
        pend = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (cyc == 0 || pend) begin
                v = '{rnd_comp(), rnd_comp(), rnd_comp()};
                drive(v);
                in_valid = 1'b1;
                pend = 1'b0;
            end
            chk("b2b.excl", bus24.in_ready && bus24.out_valid, 0);
            if (bus24.out_valid) begin
                chk("b2b.q", q.size() > 0, 1);
                if (q.size() > 0) chk_outs("b2b", q.pop_front());
            end
            if (bus24.in_ready) begin
                if (last >= 0) chk("b2b.ii", cyc - last, 5);
                last = cyc;
                q.push_back(v);
                pend = 1'b1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            if (bus24.out_valid) chk_outs("drain", q.pop_front());
            @(negedge clk);
        end
        chk("drain.empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
